// File: rtl/model_test_mac_acc_18s_if.sv
// Product-in / result-out handshake bundle for the conv MAC accumulator stage.
// master drives products, bias and out_ready; slave is the accumulator.
// Both directions use a valid/ready handshake; data is qualified by its valid.
interface model_test_mac_acc_18s_if #(
    parameter int PROD_WIDTH = 18,
    parameter int BIAS_WIDTH = 12,
    parameter int OUT_WIDTH  = 14
);
    logic signed [PROD_WIDTH-1:0] prod_data;
    logic                         prod_valid;
    logic                         prod_ready;
    logic signed [BIAS_WIDTH-1:0] bias;
    logic signed [OUT_WIDTH-1:0]  out_data;
    logic                         out_valid;
    logic                         out_ready;

    modport master (
        output prod_data, prod_valid, bias, out_ready,
        input  prod_ready, out_data, out_valid
    );

    modport slave (
        input  prod_data, prod_valid, bias, out_ready,
        output prod_ready, out_data, out_valid
    );
endinterface

// File: rtl/model_test_mac_acc_18s.sv
// Bias + N_TERMS product accumulate, round-half-up, shift, saturate (ReLU if MODEL_TEST_MAC_RELU_EN).
// Latency: out_valid visible the cycle after the last term is accepted; one result per N_TERMS+1 cycles min.
// Backpressure: prod_ready drops while a result waits in HOLD; result held stable until out_ready.
module model_test_mac_acc_18s #(
    parameter int PROD_WIDTH = 18,
    parameter int N_TERMS    = 9,
    parameter int ACC_WIDTH  = 24,
    parameter int BIAS_WIDTH = 12,
    parameter int SHIFT      = 6,
    parameter int OUT_WIDTH  = 14
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    model_test_mac_acc_18s_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

    localparam int CNT_W = $clog2(N_TERMS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);
    localparam logic signed [ACC_WIDTH-1:0] RND =
        {{(ACC_WIDTH-1){1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic signed [ACC_WIDTH-1:0] OUT_MAX =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] OUT_MIN =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    state_t                        r_state;
    logic [CNT_W-1:0]              r_cnt;
    logic signed [ACC_WIDTH-1:0]   r_acc;
    logic signed [OUT_WIDTH-1:0]   r_out_data;
    logic                          r_out_valid;
    logic                          r_prod_ready;

    logic signed [ACC_WIDTH-1:0]   w_prod_ext;
    logic signed [ACC_WIDTH-1:0]   w_bias_ext;
    logic signed [ACC_WIDTH-1:0]   w_acc_init;
    logic signed [ACC_WIDTH-1:0]   w_sum;
    logic signed [ACC_WIDTH-1:0]   w_shift;
    logic signed [OUT_WIDTH-1:0]   w_sat;
    logic signed [OUT_WIDTH-1:0]   w_result;
    logic                          w_accept;
    logic                          w_take;

    assign w_accept = bus.prod_valid && r_prod_ready;
    assign w_take   = r_out_valid && bus.out_ready;

    // Bias is pre-scaled to the accumulator's fixed point; the rounding half-LSB rides in with it.
    assign w_prod_ext = {{(ACC_WIDTH-PROD_WIDTH){bus.prod_data[PROD_WIDTH-1]}}, bus.prod_data};
    assign w_bias_ext = {{(ACC_WIDTH-BIAS_WIDTH-SHIFT){bus.bias[BIAS_WIDTH-1]}}, bus.bias, {SHIFT{1'b0}}};
    assign w_acc_init = w_prod_ext + w_bias_ext + RND;
    assign w_sum      = r_acc + w_prod_ext;
    assign w_shift    = w_sum >>> SHIFT;

    always_comb begin
        w_sat = w_shift[OUT_WIDTH-1:0];
        if (w_shift > OUT_MAX) begin
            w_sat = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end else if (w_shift < OUT_MIN) begin
            w_sat = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        end
    end

`ifdef MODEL_TEST_MAC_RELU_EN
    assign w_result = w_sat[OUT_WIDTH-1] ? '0 : w_sat;
`else
    assign w_result = w_sat;
`endif

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_acc        <= '0;
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_prod_ready <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_acc   <= w_acc_init;
                        r_cnt   <= CNT_W'(1);
                        r_state <= ACC;
                    end
                end
                ACC: begin
                    if (w_accept) begin
                        if (r_cnt == LAST_CNT) begin
                            r_acc        <= w_sum;
                            r_out_data   <= w_result;
                            r_out_valid  <= 1'b1;
                            r_cnt        <= '0;
                            r_prod_ready <= 1'b0;
                            r_state      <= HOLD;
                        end else begin
                            r_acc <= w_sum;
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (w_take) begin
                        r_out_valid  <= 1'b0;
                        r_prod_ready <= 1'b1;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_prod_ready <= 1'b1;
                    r_out_valid  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.prod_ready = r_prod_ready;
    assign bus.out_data   = r_out_data;
    assign bus.out_valid  = r_out_valid;
endmodule
